// File: rtl/axis_packet_rr_arbiter.sv
// axis_packet_rr_arbiter: packet-granular round-robin arbiter sharing one
// AXI4-Stream consumer between NUM_IN upstream streams.  A grant is taken in
// an IDLE bubble cycle and held until the tlast beat is accepted downstream.
// Optional per-requester packet counters: define AXIS_PACKET_RR_ARBITER_PKT_CNT_EN.
module axis_packet_rr_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_BYTES = 8,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_IN*DATA_BYTES*8-1:0] s_tdata,
  input  logic [NUM_IN*DATA_BYTES-1:0]   s_tkeep,
  input  logic [NUM_IN*USER_WIDTH-1:0]   s_tuser,
  input  logic [NUM_IN-1:0]              s_tlast,
  input  logic [NUM_IN-1:0]              s_tvalid,
  output logic [NUM_IN-1:0]              s_tready,
  output logic [DATA_BYTES*8-1:0]        m_tdata,
  output logic [DATA_BYTES-1:0]          m_tkeep,
  output logic [USER_WIDTH-1:0]          m_tuser,
  output logic [ID_WIDTH-1:0]            m_tid,
  output logic                           m_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           busy
`ifdef AXIS_PACKET_RR_ARBITER_PKT_CNT_EN
  ,
  input  logic                           pkt_cnt_clr,
  output logic [NUM_IN*16-1:0]           pkt_cnt
`endif
);

  localparam int DW = DATA_BYTES * 8;
  localparam int GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [GW:0] NUM_IN_W  = (GW+1)'(NUM_IN);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_IN - 1);

  // Elaboration-time parameter sanity
  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $error("axis_packet_rr_arbiter: NUM_IN must be in 2..16");
  end
  if (ID_WIDTH < GW) begin : g_bad_id_width
    $error("axis_packet_rr_arbiter: ID_WIDTH must be >= $clog2(NUM_IN)");
  end

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   pick_idx;
  logic [GW-1:0]   pick_off;
  logic [GW:0]     pick_sum;
  logic [2*NUM_IN-1:0] vld_dbl;
  logic [2*NUM_IN-1:0] vld_rot;
  logic            pkt_done;

  logic [DW-1:0]         dat_w  [NUM_IN];
  logic [DATA_BYTES-1:0] keep_w [NUM_IN];
  logic [USER_WIDTH-1:0] user_w [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign dat_w[g]  = s_tdata[g*DW +: DW];
    assign keep_w[g] = s_tkeep[g*DATA_BYTES +: DATA_BYTES];
    assign user_w[g] = s_tuser[g*USER_WIDTH +: USER_WIDTH];
  end

  // Round-robin pick: rotate valids so rr_ptr sits at bit 0, take the lowest
  // set bit, then rotate the offset back into an absolute index.
  always_comb begin
    vld_dbl  = {s_tvalid, s_tvalid};
    vld_rot  = vld_dbl >> rr_ptr_q;
    pick_off = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (vld_rot[k]) pick_off = GW'(k);
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    if (pick_sum >= NUM_IN_W) pick_sum = pick_sum - NUM_IN_W;
    pick_idx = pick_sum[GW-1:0];
  end

  // Zero-latency output mux from the granted slice; valid/ready gated by state
  always_comb begin
    m_tdata  = dat_w[grant_q];
    m_tkeep  = keep_w[grant_q];
    m_tuser  = user_w[grant_q];
    m_tlast  = s_tlast[grant_q];
    m_tid    = ID_WIDTH'(grant_q);
    busy     = (state_q == BUSY);
    m_tvalid = busy && s_tvalid[grant_q];
    s_tready = '0;
    if (busy) s_tready[grant_q] = m_tready;
  end

  assign pkt_done = m_tvalid && m_tready && m_tlast;

  // Next state: arbitrate in IDLE, hold the grant until the tlast handshake
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|s_tvalid) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (pkt_done) begin
          rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef AXIS_PACKET_RR_ARBITER_PKT_CNT_EN
  logic [NUM_IN-1:0][15:0] cnt_q;

  // Saturating per-requester packet counters; clear wins over increment
  always_ff @(posedge clk) begin
    if (reset || pkt_cnt_clr) begin
      cnt_q <= '0;
    end else if (pkt_done && cnt_q[grant_q] != 16'hFFFF) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 16'd1;
    end
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// tb_axis_packet_rr_arbiter: directed lock-step bench for the packet
// round-robin arbiter (NUM_IN=4, 8-byte data). Inputs change 1 time unit
// after posedge, outputs are sampled on negedge.
module tb_axis_packet_rr_arbiter;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int UW = 1;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*DB*8-1:0] s_tdata;
  logic [N*DB-1:0]   s_tkeep;
  logic [N*UW-1:0]   s_tuser;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tready;
  logic [DB*8-1:0]   m_tdata;
  logic [DB-1:0]     m_tkeep;
  logic [UW-1:0]     m_tuser;
  logic [IW-1:0]     m_tid;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic              busy;
`ifdef AXIS_PACKET_RR_ARBITER_PKT_CNT_EN
  logic              pkt_cnt_clr = 1'b0;
  logic [N*16-1:0]   pkt_cnt;
`endif

  logic [63:0] td [N];
  logic [N-1:0] tl;
  logic [N-1:0] tv;
  int bc [N];
  int n_chk = 0;
  int n_pass = 0;

  axis_packet_rr_arbiter #(.NUM_IN(N), .DATA_BYTES(DB), .USER_WIDTH(UW), .ID_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tid(m_tid),
    .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready), .busy(busy)
`ifdef AXIS_PACKET_RR_ARBITER_PKT_CNT_EN
    , .pkt_cnt_clr(pkt_cnt_clr), .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Requester i drives keep = F0|i and tuser = i[0] so mux faults show up
  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_tdata[i*64 +: 64] = td[i];
      s_tkeep[i*8 +: 8]   = 8'hF0 | 8'(i);
      s_tuser[i]          = 1'(i);
    end
    s_tlast  = tl;
    s_tvalid = tv;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One lock-step cycle: sample on negedge, then advance past the next posedge
  task automatic cyc(input string tag, input logic ev, input logic [1:0] etid,
                     input logic [63:0] edata, input logic elast,
                     input logic [3:0] erdy, input logic ebusy);
    @(negedge clk);
    chk({tag, " m_tvalid"}, 64'(m_tvalid), 64'(ev));
    chk({tag, " busy"}, 64'(busy), 64'(ebusy));
    chk({tag, " s_tready"}, 64'(s_tready), 64'(erdy));
    if (ebusy) chk({tag, " m_tid"}, 64'(m_tid), 64'(etid));
    if (ev) begin
      chk({tag, " m_tdata"}, m_tdata, edata);
      chk({tag, " m_tlast"}, 64'(m_tlast), 64'(elast));
      chk({tag, " m_tkeep"}, 64'(m_tkeep), 64'({4'hF, 2'b00, etid}));
      chk({tag, " m_tuser"}, 64'(m_tuser), 64'(etid[0]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tv = '0;
    tl = '0;
    m_tready = 1'b1;
    for (int i = 0; i < N; i++) td[i] = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic adv(input int t);
    bc[t]++;
    td[t] = 64'(16*t + bc[t]);
    tl[t] = bc[t][0];
  endtask

`ifdef AXIS_PACKET_RR_ARBITER_PKT_CNT_EN
  task automatic send1(input int i, input logic [63:0] d);
    logic ok;
    ok = 1'b0;
    tv[i] = 1'b1;
    tl[i] = 1'b1;
    td[i] = d;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (s_tready[i] && m_tvalid) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    tv[i] = 1'b0;
    tl[i] = 1'b0;
    chk($sformatf("send1 req%0d handshake", i), 64'(ok), 64'd1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset holds IDLE even with every requester valid
    reset = 1'b1; m_tready = 1'b1; tl = '0; tv = 4'hF;
    for (int i = 0; i < N; i++) td[i] = '0;
    cyc("rst", 1'b0, 2'd0, 64'h0, 1'b0, 4'b0000, 1'b0);
    do_reset();
    for (int c = 0; c < 10; c++) cyc("idle", 1'b0, 2'd0, 64'h0, 1'b0, 4'b0000, 1'b0);

    // Requester 2 alone, 3-beat packet
    tv = 4'b0100; td[2] = 64'hA0;
    cyc("t2 bubble", 1'b0, 2'd0, 64'h0, 1'b0, 4'b0000, 1'b0);
    cyc("t2 b0", 1'b1, 2'd2, 64'hA0, 1'b0, 4'b0100, 1'b1);
    td[2] = 64'hA1;
    cyc("t2 b1", 1'b1, 2'd2, 64'hA1, 1'b0, 4'b0100, 1'b1);
    td[2] = 64'hA2; tl[2] = 1'b1;
    cyc("t2 b2", 1'b1, 2'd2, 64'hA2, 1'b1, 4'b0100, 1'b1);
    tv = '0; tl = '0;
    cyc("t2 done", 1'b0, 2'd0, 64'h0, 1'b0, 4'b0000, 1'b0);

    // All four valid, 2-beat packets back to back: 0,1,2,3,0,1
    do_reset();
    for (int i = 0; i < N; i++) begin bc[i] = 0; td[i] = 64'(16*i); end
    tv = 4'hF;
    for (int p = 0; p < 6; p++) begin
      int t;
      t = p % 4;
      cyc($sformatf("t3 p%0d bubble", p), 1'b0, 2'd0, 64'h0, 1'b0, 4'b0000, 1'b0);
      cyc($sformatf("t3 p%0d b0", p), 1'b1, 2'(t), 64'(16*t + 2*(p/4)), 1'b0, 4'(1 << t), 1'b1);
      adv(t);
      cyc($sformatf("t3 p%0d b1", p), 1'b1, 2'(t), 64'(16*t + 2*(p/4) + 1), 1'b1, 4'(1 << t), 1'b1);
      adv(t);
    end
    tv = '0; tl = '0;

    // Requester 1 with ready toggling and a 2-cycle valid gap; 3 waits
    do_reset();
    tv = 4'b1010; td[1] = 64'hB0; td[3] = 64'hC0; tl[3] = 1'b1;
    cyc("t4 bubble", 1'b0, 2'd0, 64'h0, 1'b0, 4'b0000, 1'b0);
    cyc("t4 b0", 1'b1, 2'd1, 64'hB0, 1'b0, 4'b0010, 1'b1);
    td[1] = 64'hB1; m_tready = 1'b0;
    cyc("t4 stall rdy", 1'b1, 2'd1, 64'hB1, 1'b0, 4'b0000, 1'b1);
    m_tready = 1'b1; tv[1] = 1'b0;
    cyc("t4 gap0", 1'b0, 2'd1, 64'h0, 1'b0, 4'b0010, 1'b1);
    m_tready = 1'b0;
    cyc("t4 gap1", 1'b0, 2'd1, 64'h0, 1'b0, 4'b0000, 1'b1);
    m_tready = 1'b1; tv[1] = 1'b1;
    cyc("t4 b1", 1'b1, 2'd1, 64'hB1, 1'b0, 4'b0010, 1'b1);
    td[1] = 64'hB2; tl[1] = 1'b1; m_tready = 1'b0;
    cyc("t4 stall b2", 1'b1, 2'd1, 64'hB2, 1'b1, 4'b0000, 1'b1);
    m_tready = 1'b1;
    cyc("t4 b2", 1'b1, 2'd1, 64'hB2, 1'b1, 4'b0010, 1'b1);
    tv[1] = 1'b0; tl[1] = 1'b0;
    cyc("t4 bubble3", 1'b0, 2'd0, 64'h0, 1'b0, 4'b0000, 1'b0);
    cyc("t4 req3", 1'b1, 2'd3, 64'hC0, 1'b1, 4'b1000, 1'b1);
    tv = '0; tl = '0;
    cyc("t4 done", 1'b0, 2'd0, 64'h0, 1'b0, 4'b0000, 1'b0);

    // Reset mid-packet: rr_ptr left at 2 by a req1 packet, then cleared
    do_reset();
    tv = 4'b0010; td[1] = 64'h11; tl[1] = 1'b1;
    cyc("t5 bubble1", 1'b0, 2'd0, 64'h0, 1'b0, 4'b0000, 1'b0);
    cyc("t5 req1", 1'b1, 2'd1, 64'h11, 1'b1, 4'b0010, 1'b1);
    tv = 4'b1000; tl = '0; td[3] = 64'hD0;
    cyc("t5 bubble3", 1'b0, 2'd0, 64'h0, 1'b0, 4'b0000, 1'b0);
    cyc("t5 d0", 1'b1, 2'd3, 64'hD0, 1'b0, 4'b1000, 1'b1);
    td[3] = 64'hD1; reset = 1'b1;
    cyc("t5 d1 rst", 1'b1, 2'd3, 64'hD1, 1'b0, 4'b1000, 1'b1);
    reset = 1'b0; tv = 4'b1001; td[0] = 64'hE0; tl[0] = 1'b1; td[3] = 64'hD0;
    cyc("t5 post rst", 1'b0, 2'd0, 64'h0, 1'b0, 4'b0000, 1'b0);
    cyc("t5 grant0", 1'b1, 2'd0, 64'hE0, 1'b1, 4'b0001, 1'b1);
    tv[0] = 1'b0; tl[0] = 1'b0;
    cyc("t5 bubble", 1'b0, 2'd0, 64'h0, 1'b0, 4'b0000, 1'b0);
    cyc("t5 grant3", 1'b1, 2'd3, 64'hD0, 1'b0, 4'b1000, 1'b1);
    tv = '0;

`ifdef AXIS_PACKET_RR_ARBITER_PKT_CNT_EN
    do_reset();
    for (int k = 0; k < 5; k++) send1(0, 64'(k));
    for (int k = 0; k < 2; k++) send1(1, 64'(k));
    @(negedge clk);
    chk("cnt0", 64'(pkt_cnt[15:0]), 64'd5);
    chk("cnt1", 64'(pkt_cnt[31:16]), 64'd2);
    chk("cnt2", 64'(pkt_cnt[47:32]), 64'd0);
    @(posedge clk); #1;
    pkt_cnt_clr = 1'b1;
    tick();
    pkt_cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt clr", pkt_cnt, 64'h0);
    @(posedge clk); #1;
    force dut.cnt_q = 64'h0000_FFFF_0000_0000;
    tick();
    release dut.cnt_q;
    send1(2, 64'h77);
    @(negedge clk);
    chk("cnt2 sat", 64'(pkt_cnt[47:32]), 64'hFFFF);
    @(posedge clk); #1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_packet_rr_arbiter.md
Name: axis_packet_rr_arbiter

Overview:
- Packet-granular round-robin arbiter. It shares one downstream AXI4-Stream consumer, typically a width adapter feeding a serial link, between NUM_IN upstream streams of identical width.
- A grant is held from the first beat of a packet through the beat carrying tlast, so packets never interleave.
- Sits directly upstream of the stream width adapter in the TX datapath.

Parameters:
- NUM_IN, 4, number of requesters; legal range 2..16.
- DATA_BYTES, 8, tdata width in bytes on every port.
- USER_WIDTH, 1, tuser width; passed through unchanged.
- ID_WIDTH, 2, width of m_tid. Must be >= $clog2(NUM_IN); elaboration check enforces this.

Ports:
- clk  in  1  Single clock for all logic.
- reset  in  1  Synchronous, active-high reset.
- s_tdata  in  NUM_IN*DATA_BYTES*8  Packed input data; requester i occupies slice i.
- s_tkeep  in  NUM_IN*DATA_BYTES  Packed input byte enables.
- s_tuser  in  NUM_IN*USER_WIDTH  Packed input user bits.
- s_tlast  in  NUM_IN  Per-requester end of packet.
- s_tvalid  in  NUM_IN  Per-requester valid.
- s_tready  out  NUM_IN  Per-requester ready.
- m_tdata  out  DATA_BYTES*8  Output data.
- m_tkeep  out  DATA_BYTES  Output byte enables.
- m_tuser  out  USER_WIDTH  Output user bits.
- m_tid  out  ID_WIDTH  Index of the granted requester.
- m_tlast  out  1  Output end of packet.
- m_tvalid  out  1  Output valid.
- m_tready  in  1  Output ready.
- busy  out  1  High while a packet grant is held.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: state=IDLE, grant=0, rr_ptr=0, busy=0, m_tvalid=0, s_tready=all 0. m_tdata, m_tkeep, m_tuser, m_tid and m_tlast drive slice 0 and are don't-care while m_tvalid=0.
- State IDLE:
  - s_tready all 0; m_tvalid=0.
  - If any s_tvalid is high, pick the first valid index searching from rr_ptr upward with wrap-around, inclusive of rr_ptr.
  - Register the chosen index as grant and go to BUSY. This costs one arbitration bubble cycle.
- State BUSY:
  - Output mux is combinational from s_*[grant] to m_*, with zero latency.
  - m_tvalid = s_tvalid[grant].
  - s_tready[grant] = m_tready; every other s_tready = 0.
  - m_tid = grant, zero-extended to ID_WIDTH.
  - busy = 1.
  - On a handshake (m_tvalid && m_tready && m_tlast): rr_ptr <= (grant+1) mod NUM_IN, then go to IDLE.
  - The last requester wraps to index 0.
- Handshake rules:
  - The grant never changes while in BUSY, even if s_tvalid[grant] deasserts mid-packet. The output simply stalls.
  - No combinational path from m_tready to any s_tvalid-dependent decision in IDLE.
  - s_tready to any non-granted requester is always 0.
- Single-beat packet (tlast on the first beat): one beat in BUSY, then IDLE. Sustained throughput is one beat per two cycles for 1-beat packets.
- Fairness: with all requesters valid, grants cycle 0,1,2,...,NUM_IN-1,0. A requester waits at most NUM_IN-1 packets.
- Reset asserted mid-packet: the packet is abandoned, with no tlast emitted downstream. The next cycle is in IDLE with rr_ptr=0. Downstream must be reset by the same reset.
- Simultaneous events: a tlast handshake and new s_tvalid on other ports in the same cycle. Arbitration still takes place in the following IDLE cycle, using the updated rr_ptr.

Optional Feature:
- Macro: AXIS_PACKET_RR_ARBITER_PKT_CNT_EN.
- When defined: extra output port pkt_cnt, out, NUM_IN*16 bits.
  - One 16-bit counter per requester, incremented on every tlast handshake from that requester.
  - Counters saturate at 16'hFFFF and reset to 0.
  - Additional input pkt_cnt_clr, in, 1 bit, synchronous: clears all counters.
  - If clr and an increment occur in the same cycle, the counter becomes 0.
- When undefined: neither port nor counters exist; arbitration behaviour is unchanged.

Test Plan:
- Reset, then s_tvalid=4'b0000 for 10 cycles -> m_tvalid=0, s_tready=0, busy=0 throughout.
- Requester 2 alone sends a 3-beat packet, data 0xA0,0xA1,0xA2, m_tready=1 -> m_tdata in that order with m_tid=2. First output beat appears 1 cycle after s_tvalid[2] rises; tlast is on the third beat; busy drops the cycle after.
- All 4 requesters valid, each sending 2-beat packets continuously -> m_tid sequence 0,1,2,3,0,1 and no interleaving. Each packet takes 3 cycles, including the bubble.
- Requester 1 granted, m_tready toggles 1,0,1,0 and s_tvalid[1] drops for 2 cycles mid-packet while requester 3 is valid -> no grant switch and no beat loss; requester 3 is served next.
- Reset asserted on the 2nd beat of a 4-beat packet from requester 3 -> next cycle is IDLE with rr_ptr=0. With requesters 0 and 3 valid afterwards, requester 0 is granted first.
- With AXIS_PACKET_RR_ARBITER_PKT_CNT_EN defined: 5 packets from requester 0 and 2 from requester 1 -> pkt_cnt slice 0 = 5, slice 1 = 2. Pulsing pkt_cnt_clr gives all 0. A counter preloaded to 16'hFFFF by force stays at 16'hFFFF after another packet.
